// File: rtl/demo_diagnostic_pkg.sv
// Purpose: shared types and defaults for the diagnostic two-master RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arbiter FSM state type, default geometry, value returned for out-of-range reads.
package demo_diagnostic_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 51200;
  localparam int DEF_MAX_BURST = 4;

  // Read data returned for an address beyond the implemented depth; sliced to DATA_W.
  localparam logic [255:0] OOR_READ_VALUE = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/demo_diagnostic_rr_grant.sv
// Purpose: grant/burst decision between two masters (IDLE/OWN0/OWN1 with burst limit).
// Latency: grant is combinational from requests in the same cycle; state updates on clk.
// Backpressure: no grant during freeze or reset; state holds while frozen.
// Ports: clk, reset (sync, active-high), freeze, req0/req1 in; gnt0/gnt1 out (one-hot or zero).
module demo_diagnostic_rr_grant
  import demo_diagnostic_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk,
  input  logic reset,
  input  logic freeze,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_served_q, last_served_d;
  logic             sel_vld;
  logic             sel_m1;
  arb_state_e       sel_state;

  always_comb begin
    sel_vld = 1'b0;
    sel_m1  = 1'b0;
    case (state_q)
      ST_OWN0: begin
        // Owner keeps the grant unless its burst is spent and the other side waits.
        if (req0 && !(burst_cnt_q == CNT_MAX && req1)) begin
          sel_vld = 1'b1;
        end else if (req1) begin
          sel_vld = 1'b1;
          sel_m1  = 1'b1;
        end
      end
      ST_OWN1: begin
        if (req1 && !(burst_cnt_q == CNT_MAX && req0)) begin
          sel_vld = 1'b1;
          sel_m1  = 1'b1;
        end else if (req0) begin
          sel_vld = 1'b1;
        end
      end
      default: begin
        if (req0 && req1) begin
          sel_vld = 1'b1;
          sel_m1  = ~last_served_q;
        end else if (req0) begin
          sel_vld = 1'b1;
        end else if (req1) begin
          sel_vld = 1'b1;
          sel_m1  = 1'b1;
        end
      end
    endcase
    if (freeze || reset) begin
      sel_vld = 1'b0;
    end

    gnt0      = sel_vld & ~sel_m1;
    gnt1      = sel_vld & sel_m1;
    sel_state = sel_m1 ? ST_OWN1 : ST_OWN0;

    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    last_served_d = last_served_q;
    if (sel_vld) begin
      last_served_d = sel_m1;
      if (state_q == sel_state) begin
        if (burst_cnt_q != CNT_MAX) begin
          burst_cnt_d = burst_cnt_q + CNT_ONE;
        end
      end else begin
        state_d     = sel_state;
        burst_cnt_d = CNT_ONE;
      end
    end else if (!freeze) begin
      // Nobody requesting: release ownership.
      state_d     = ST_IDLE;
      burst_cnt_d = CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      burst_cnt_q   <= CNT_ONE;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      last_served_q <= last_served_d;
    end
  end

endmodule

// File: rtl/demo_diagnostic_ram_arbiter.sv
// Purpose: two Avalon-style masters sharing one single-port RAM, burst-limited round robin.
// Latency: request to RAM combinational in accept cycle; readdatavalid one cycle after accept.
// Backpressure: mN_waitrequest high when not granted, during freeze and during reset.
// Ports: clk, reset; m0_*/m1_* master ports; freeze; ram_* port-A drive and ram_readdata; out_of_range sticky flag.
module demo_diagnostic_ram_arbiter
  import demo_diagnostic_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  input  logic                freeze,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                out_of_range
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              gnt0, gnt1;
  logic              acc, acc_wr, in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] rd_data;

  // One-entry return tag: the RAM has a fixed one-cycle read latency.
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              rd_oor_q, rd_oor_d;
  logic              oor_q, oor_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;

  demo_diagnostic_rr_grant #(
    .MAX_BURST(MAX_BURST)
  ) u_grant (
    .clk   (clk),
    .reset (reset),
    .freeze(freeze),
    .req0  (m0_read | m0_write),
    .req1  (m1_read | m1_write),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    acc      = gnt0 | gnt1;
    acc_addr = gnt1 ? m1_address : m0_address;
    // read+write together from one master is a write.
    acc_wr   = gnt1 ? m1_write : m0_write;
    in_range = ({1'b0, acc_addr} < DEPTH_L);

    ram_address    = acc_addr;
    ram_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    ram_writedata  = gnt1 ? m1_writedata : m0_writedata;
    ram_chipselect = acc & in_range;
    ram_write      = acc & acc_wr & in_range;
    ram_clken      = ~reset;

    m0_waitrequest = ~gnt0;
    m1_waitrequest = ~gnt1;

    rd_pend_d  = acc & ~acc_wr;
    rd_owner_d = gnt1;
    rd_oor_d   = ~in_range;
    oor_d      = oor_q | (acc & ~in_range);

    rd_data = rd_oor_q ? OOR_READ_VALUE[DATA_W-1:0] : ram_readdata;

    // Gate with reset so a read issued just before reset never returns.
    m0_readdatavalid = rd_pend_q & ~rd_owner_q & ~reset;
    m1_readdatavalid = rd_pend_q & rd_owner_q & ~reset;

    hold0_d = m0_readdatavalid ? rd_data : hold0_q;
    hold1_d = m1_readdatavalid ? rd_data : hold1_q;

    m0_readdata  = reset ? '0 : hold0_d;
    m1_readdata  = reset ? '0 : hold1_d;
    out_of_range = oor_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      oor_q      <= 1'b0;
      hold0_q    <= '0;
      hold1_q    <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      oor_q      <= oor_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
    end
  end

endmodule

// File: tb/tb_demo_diagnostic_ram_arbiter.sv
// Purpose: directed self-checking bench for demo_diagnostic_ram_arbiter with a behavioural RAM.
// Latency: inputs driven 1 ns after posedge, outputs sampled on negedge.
// Backpressure: fixed directed cycle counts; no open-ended waits.
module tb_demo_diagnostic_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        freeze;
  logic [15:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata = 32'h0;
  logic        out_of_range;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demo_diagnostic_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .freeze(freeze),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
    .out_of_range(out_of_range)
  );

  // Behavioural single-port RAM, one-cycle read latency, low 8 address bits decoded.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address[7:0]][8*b +: 8] <= ram_writedata[8*b +: 8];
      end
      ram_readdata <= mem[ram_address[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  initial begin
    idle_all();
    freeze = 0;
    reset  = 1;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdata0", m0_readdata, 0);
    chk("rst_oor", out_of_range, 0);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_clken", ram_clken, 0);
    tick();
    reset = 0;
    @(negedge clk);
    chk("clken_run", ram_clken, 1);

    // m0 write then read back
    tick();
    m0_write = 1; m0_address = 16'h0010; m0_writedata = 32'hA5A5_0001;
    @(negedge clk);
    chk("m0wr_wait", m0_waitrequest, 0);
    chk("m0wr_cs", ram_chipselect, 1);
    chk("m0wr_we", ram_write, 1);
    chk("m0wr_addr", ram_address, 32'h10);
    tick();
    m0_write = 0; m0_read = 1;
    @(negedge clk);
    chk("m0rd_wait", m0_waitrequest, 0);
    chk("m0rd_we", ram_write, 0);
    tick();
    m0_read = 0;
    @(negedge clk);
    chk("m0rd_rdv", m0_readdatavalid, 1);
    chk("m0rd_data", m0_readdata, 32'hA5A5_0001);
    chk("m0rd_rdv1", m1_readdatavalid, 0);
    tick();
    @(negedge clk);
    chk("m0rd_rdv_end", m0_readdatavalid, 0);
    chk("m0rd_hold", m0_readdata, 32'hA5A5_0001);

    // m1 byte-lane write
    tick();
    m1_write = 1; m1_address = 16'd5; m1_writedata = 32'h1122_3344; m1_byteenable = 4'hF;
    @(negedge clk);
    chk("m1wr_wait", m1_waitrequest, 0);
    tick();
    m1_byteenable = 4'h2; m1_writedata = 32'h0000_BB00;
    tick();
    m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
    tick();
    m1_read = 0;
    @(negedge clk);
    chk("m1be_rdv", m1_readdatavalid, 1);
    chk("m1be_data", m1_readdata, 32'h1122_BB44);

    // Both masters read continuously: 4/4/4 burst pattern, in-order returns
    tick();
    m0_read = 1; m0_address = 16'h0010;
    m1_read = 1; m1_address = 16'd5;
    for (int i = 0; i < 12; i++) begin
      logic exp0, prev0;
      exp0  = ((i / 4) % 2) == 0;
      prev0 = (((i - 1) / 4) % 2) == 0;
      @(negedge clk);
      chk($sformatf("burst_wait0_%0d", i), m0_waitrequest, !exp0);
      chk($sformatf("burst_wait1_%0d", i), m1_waitrequest, exp0);
      if (i > 0) begin
        chk($sformatf("burst_rdv0_%0d", i), m0_readdatavalid, prev0);
        chk($sformatf("burst_rdv1_%0d", i), m1_readdatavalid, !prev0);
        chk($sformatf("burst_data_%0d", i), prev0 ? m0_readdata : m1_readdata,
            prev0 ? 32'hA5A5_0001 : 32'h1122_BB44);
      end
      tick();
    end
    idle_all();
    @(negedge clk);
    chk("burst_last_rdv0", m0_readdatavalid, 1);
    chk("burst_last_rdv1", m1_readdatavalid, 0);

    // Out-of-range read
    tick();
    m0_read = 1; m0_address = 16'd51200;
    @(negedge clk);
    chk("oor_wait", m0_waitrequest, 0);
    chk("oor_cs", ram_chipselect, 0);
    chk("oor_flag_pre", out_of_range, 0);
    tick();
    m0_read = 0;
    @(negedge clk);
    chk("oor_rdv", m0_readdatavalid, 1);
    chk("oor_data", m0_readdata, 0);
    chk("oor_flag", out_of_range, 1);
    tick();
    tick();
    @(negedge clk);
    chk("oor_sticky", out_of_range, 1);

    // Read accepted, reset next cycle
    tick();
    m0_read = 1; m0_address = 16'h0010;
    @(negedge clk);
    chk("prerst_wait", m0_waitrequest, 0);
    tick();
    m0_read = 0; reset = 1;
    @(negedge clk);
    chk("rst2_rdv0", m0_readdatavalid, 0);
    chk("rst2_rdata0", m0_readdata, 0);
    chk("rst2_wait0", m0_waitrequest, 1);
    chk("rst2_clken", ram_clken, 0);
    tick();
    @(negedge clk);
    chk("rst2_oor", out_of_range, 0);
    chk("rst2_cs", ram_chipselect, 0);
    tick();
    reset = 0;
    @(negedge clk);
    chk("rst2_after_rdv0", m0_readdatavalid, 0);
    chk("rst2_after_rdata0", m0_readdata, 0);

    // Freeze with both requesting, then release; freeze does not cancel a read in flight
    tick();
    freeze = 1;
    m0_read = 1; m0_address = 16'h0010;
    m1_read = 1; m1_address = 16'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("frz_wait0_%0d", i), m0_waitrequest, 1);
      chk($sformatf("frz_wait1_%0d", i), m1_waitrequest, 1);
      chk($sformatf("frz_cs_%0d", i), ram_chipselect, 0);
      tick();
    end
    freeze = 0;
    @(negedge clk);
    chk("rel_wait0", m0_waitrequest, 0);
    chk("rel_wait1", m1_waitrequest, 1);
    chk("rel_addr", ram_address, 32'h10);
    tick();
    freeze = 1;
    @(negedge clk);
    chk("frz2_rdv0", m0_readdatavalid, 1);
    chk("frz2_data", m0_readdata, 32'hA5A5_0001);
    chk("frz2_wait0", m0_waitrequest, 1);
    chk("frz2_wait1", m1_waitrequest, 1);
    tick();
    idle_all();
    freeze = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/demo_diagnostic_ram_arbiter.md
DEMO_DIAGNOSTIC_RAM_ARBITER -- requirements
Module: demo_diagnostic_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Parameter DEPTH, default 51200, number of implemented RAM words.
REQ-004 Parameter MAX_BURST, default 4, maximum consecutive accepted transfers per grant while the other master waits.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 mN_address  in  ADDR_W  word address of master N (N = 0, 1).
REQ-008 mN_byteenable  in  DATA_W/8  byte lanes of master N.
REQ-009 mN_read, mN_write  in  1  request strobes of master N.
REQ-010 mN_writedata  in  DATA_W  write data of master N.
REQ-011 mN_waitrequest  out  1  master N request not accepted this cycle.
REQ-012 mN_readdata  out  DATA_W  read data returned to master N.
REQ-013 mN_readdatavalid  out  1  mN_readdata valid this cycle.
REQ-014 freeze  in  1  hold: no new transfer accepted while high.
REQ-015 ram_address, ram_byteenable, ram_writedata  out  ADDR_W, DATA_W/8, DATA_W  RAM port A drive.
REQ-016 ram_chipselect, ram_write, ram_clken  out  1  RAM control; ram_clken constant 1 outside reset.
REQ-017 ram_readdata  in  DATA_W  RAM q, valid the cycle after the read is issued.
REQ-018 out_of_range  out  1  sticky flag: an accepted access had address >= DEPTH.

Function
REQ-019 At most one transfer SHALL be accepted per cycle; accepted means mN_(read|write) high and mN_waitrequest low in the same cycle.
REQ-020 mN_waitrequest SHALL be high whenever master N requests and is not the master selected this cycle, during freeze, and during reset.
REQ-021 Selection: FSM states IDLE, OWN0, OWN1; in IDLE a sole requester wins; on simultaneous requests the master not served most recently wins (last_served resets to 1, so m0 wins first).
REQ-022 In OWNn, master n SHALL keep the grant while requesting, until burst_cnt reaches MAX_BURST with the other master requesting; the grant then moves to OWN(other) in the same cycle with burst_cnt reset to 1.
REQ-023 burst_cnt SHALL count accepted transfers in the current ownership, saturating at MAX_BURST; it SHALL reset to 1 on every ownership change.
REQ-024 When the owner drops its request, the grant SHALL pass to the other master in the same cycle if it requests, else the FSM SHALL go to IDLE.
REQ-025 The accepted master's address, byteenable and writedata SHALL drive the RAM combinationally in the accept cycle; ram_chipselect high on accept.
REQ-026 read and write both high from one master SHALL be treated as a write; no readdatavalid is produced.
REQ-027 An accepted read SHALL assert mN_readdatavalid for exactly one cycle, one cycle after acceptance, with mN_readdata = ram_readdata; the other master's readdatavalid stays low.
REQ-028 mN_readdata SHALL be registered-hold: it keeps its last value when readdatavalid is low.
REQ-029 Back-to-back reads (including alternating masters) SHALL sustain one transfer per cycle with in-order return tagged by a one-entry owner register.
REQ-030 Address >= DEPTH: transfer accepted, ram_chipselect and ram_write suppressed, read returns 0 with readdatavalid, out_of_range set until reset.
REQ-031 freeze SHALL not cancel a read already accepted; its readdatavalid still occurs.

Reset
REQ-032 On reset: FSM IDLE, burst_cnt 1, last_served 1, pending read cleared, all readdatavalid 0, readdata 0, out_of_range 0, ram_chipselect/ram_write/ram_clken 0, waitrequest 1.
REQ-033 A read accepted in the cycle before reset SHALL NOT produce readdatavalid after reset.

Structure
REQ-034 FSM state typedef, ADDR_W/DATA_W/DEPTH defaults and the out-of-range read value SHALL live in a shared demo_diagnostic_pkg.
REQ-035 The grant/burst decision SHALL be one sub-module, demo_diagnostic_rr_grant; datapath mux and return logic stay in the top.

Verification
REQ-036 m0 writes 0xA5A5_0001 at addr 0x0010, then reads it -> m0_readdatavalid one cycle after accept, data 0xA5A5_0001, m1 signals idle.
REQ-037 Both masters continuously read, MAX_BURST=4 -> accept pattern m0 x4, m1 x4, m0 x4; no cycle without acceptance.
REQ-038 m1 writes byteenable 0x2 data 0x0000_BB00 over 0x1122_3344 at addr 5, then reads -> 0x1122_BB44.
REQ-039 m0 reads addr 51200 -> accepted, ram_chipselect 0, readdata 0, out_of_range 1 until reset.
REQ-040 m0 read accepted, reset next cycle -> no readdatavalid; all outputs at REQ-032 values.
REQ-041 freeze high 3 cycles with both requesting -> both waitrequest 1, no RAM access; on release m0 (per last_served) accepted first.
